// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered ALU: opcodes, flag bit positions
// and the sequencing states.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DEP  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_ORA  = 4'h5;
  localparam logic [3:0] OP_EOR  = 4'h6;
  localparam logic [3:0] OP_LDA  = 4'h7;
  localparam logic [3:0] OP_EXT  = 4'h8;
  localparam logic [3:0] OP_BSW  = 4'h9;
  localparam logic [3:0] OP_LSR  = 4'hA;
  localparam logic [3:0] OP_ASL  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_LDZ2 = 4'hE;
  localparam logic [3:0] OP_LDZ3 = 4'hF;

  localparam int SF_C  = 0;
  localparam int SF_V  = 1;
  localparam int SF_Z  = 2;
  localparam int SF_N  = 3;
  localparam int SF_A  = 4;
  localparam int SF_DZ = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] f);
    return (f == OP_MUL) || (f == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// lo/hi present the value after the current step, so the caller captures on done.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, q_q, m_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] acc_nxt, q_nxt;

  // acc holds the product high half / partial remainder; q holds the
  // multiplier being consumed / the dividend being replaced by quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_q, q_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    acc_nxt   = acc_q;
    q_nxt     = q_q;
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_nxt = div_diff[WIDTH-1:0];
        q_nxt   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift[WIDTH-1:0];
        q_nxt   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      q_nxt   = {mul_sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      acc_q <= '0;
      q_q   <= a;
      m_q   <= b;
      cnt_q <= CW'(WIDTH);
      div_q <= op_div;
    end else if (cnt_q != '0) begin
      acc_q <= acc_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // A zero divisor runs the full iteration count and naturally yields
  // quotient all-ones and remainder = dividend.
  assign done = (cnt_q == CW'(1));
  assign lo   = q_nxt;
  assign hi   = acc_nxt;
  assign dz   = div_q & (m_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, internal status flags and an
// optional iterative multiply/divide unit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no result held; ready for a new operation
// ST_EXEC | MUL/DIV iterating; waits for the iterative unit's done
// ST_DONE | result valid on d/d_hi/sf; held until out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_f,
  input  logic             carry_mask,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_hi,
  output logic [15:0]      sf,
  output logic             busy
);

  localparam int H = WIDTH / 2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, dhi_q;
  logic [5:0]       flags_q;

  logic             iter_op, accept, load_base, iter_start, load_iter;
  logic [3:0]       f_eff;
  logic             cin;
  logic [WIDTH:0]   add_r, sub_r, inc_r;
  logic [WIDTH-1:0] base_d;
  logic             base_c, base_v, base_a;

  logic             it_done, it_c, it_v, it_dz;
  logic [WIDTH-1:0] it_lo, it_hi;

  assign iter_op = MULDIV_EN && is_muldiv(alu_f);
  assign f_eff   = (!MULDIV_EN && is_muldiv(alu_f)) ? OP_LDZ2 : alu_f;
  assign cin     = flags_q[SF_C] & carry_mask;

  always_comb begin
    add_r  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_r  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, (carry_mask ? flags_q[SF_C] : 1'b1)};
    inc_r  = {1'b0, b} + (WIDTH+1)'(1);
    base_d = '0;
    base_c = 1'b0;
    base_v = 1'b0;
    base_a = 1'b0;
    case (f_eff)
      OP_ADD: begin
        {base_c, base_d} = add_r;
        base_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: {base_c, base_d} = inc_r;
      OP_SUB: begin
        {base_c, base_d} = sub_r;
        base_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DEP: begin
        base_d = b - WIDTH'(b != '0);
        base_a = (b != '0);
      end
      OP_AND: base_d = a & b;
      OP_ORA: base_d = a | b;
      OP_EOR: base_d = a ^ b;
      OP_LDA: base_d = b;
      OP_EXT: base_d = {{H{b[H-1]}}, b[H-1:0]};
      OP_BSW: base_d = {b[H-1:0], b[WIDTH-1:H]};
      OP_LSR: begin
        base_d = {cin, b[WIDTH-1:1]};
        base_c = b[0];
      end
      OP_ASL: begin
        base_d = {b[WIDTH-2:0], cin};
        base_c = b[WIDTH-1];
      end
      default: base_d = '0;
    endcase
  end

  // DONE can accept the next op in the same cycle it retires, skipping IDLE.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = iter_op ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (it_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_d = iter_op ? ST_EXEC : ST_DONE;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign load_base  = accept & ~iter_op;
  assign iter_start = accept & iter_op;
  assign load_iter  = (state_q == ST_EXEC) & it_done;

  generate
    if (MULDIV_EN) begin : g_muldiv
      logic div_q;
      logic dz_raw;

      alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .op_div (alu_f == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (it_done),
        .lo     (it_lo),
        .hi     (it_hi),
        .dz     (dz_raw)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst)             div_q <= 1'b0;
        else if (iter_start) div_q <= (alu_f == OP_DIV);
      end

      assign it_c  = ~div_q & (it_hi != '0);
      assign it_v  = div_q & dz_raw;
      assign it_dz = div_q & dz_raw;
    end else begin : g_no_muldiv
      assign it_done = 1'b0;
      assign it_lo   = '0;
      assign it_hi   = '0;
      assign it_c    = 1'b0;
      assign it_v    = 1'b0;
      assign it_dz   = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      dhi_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_base) begin
        d_q     <= base_d;
        dhi_q   <= '0;
        flags_q <= {1'b0, base_a, base_d[WIDTH-1], (base_d == '0), base_v, base_c};
      end else if (load_iter) begin
        d_q     <= it_lo;
        dhi_q   <= it_hi;
        flags_q <= {it_dz, 1'b0, it_lo[WIDTH-1], (it_lo == '0), it_v, it_c};
      end
    end
  end

  assign d    = d_q;
  assign d_hi = dhi_q;
  assign sf   = {10'b0, flags_q};

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: 16-bit instance for the op set, handshake,
// latency and reset behaviour; 32-bit instance for wide shift/rotate.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, carry_mask, out_valid, out_ready, busy;
  logic [3:0]  alu_f;
  logic [15:0] a, b, d, d_hi, sf;

  logic        in_valid_w, in_ready_w, carry_mask_w, out_valid_w, out_ready_w, busy_w;
  logic [3:0]  alu_f_w;
  logic [31:0] a_w, b_w, d_w, d_hi_w;
  logic [15:0] sf_w;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_f(alu_f),
    .carry_mask(carry_mask), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .d_hi(d_hi), .sf(sf), .busy(busy)
  );

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .alu_f(alu_f_w),
    .carry_mask(carry_mask_w), .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .d(d_w), .d_hi(d_hi_w), .sf(sf_w), .busy(busy_w)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] hi;
    logic [5:0]  sf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   wt, lat, bcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_pending", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("res_d", d, mon_e.d);
        chk("res_dhi", d_hi, mon_e.hi);
        chk("res_sf", sf, {10'b0, mon_e.sf});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] f, input logic m, input logic [15:0] aa, input logic [15:0] bb,
                       input logic [15:0] ed, input logic [15:0] eh, input logic [5:0] es,
                       output int waited);
    exp_t e;
    alu_f = f; carry_mask = m; a = aa; b = bb; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    chk("accept", in_ready, 1);
    e.d = ed; e.hi = eh; e.sf = es;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic measure(output int l, output int bn);
    l = 1; bn = 0;
    @(negedge clk);
    while (!out_valid && l < 60) begin
      if (busy) bn++;
      l++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op_w(input logic [3:0] f, input logic m, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] ed, input logic [5:0] es);
    alu_f_w = f; carry_mask_w = m; a_w = aa; b_w = bb; in_valid_w = 1'b1;
    @(negedge clk);
    chk("w_rdy", in_ready_w, 1);
    @(posedge clk);
    #1 in_valid_w = 1'b0;
    @(negedge clk);
    chk("w_valid", out_valid_w, 1);
    chk("w_d", d_w, ed);
    chk("w_sf", sf_w, {10'b0, es});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    in_valid = 0; out_ready = 1; alu_f = 0; carry_mask = 0; a = 0; b = 0;
    in_valid_w = 0; out_ready_w = 1; alu_f_w = 0; carry_mask_w = 0; a_w = 0; b_w = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_dhi", d_hi, 0);
    chk("rst_sf", sf, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(posedge clk);
    #1;

    issue(OP_ADD, 0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 6'h0A, wt);
    measure(lat, bcnt);
    chk("add_latency", lat, 1);

    issue(OP_SUB, 0, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 6'h08, wt);
    issue(OP_SUB, 1, 16'h0005, 16'h0001, 16'h0003, 16'h0000, 6'h01, wt);
    chk("b2b_wait", wt, 0);
    issue(OP_ADD, 1, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 6'h00, wt);
    issue(OP_SUB, 0, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 6'h03, wt);
    issue(OP_INC, 0, 16'h0000, 16'h0041, 16'h0042, 16'h0000, 6'h00, wt);
    issue(OP_AND, 0, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 6'h08, wt);
    issue(OP_ORA, 0, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 6'h08, wt);
    issue(OP_EOR, 0, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 6'h04, wt);
    issue(OP_LDA, 0, 16'h5555, 16'h1234, 16'h1234, 16'h0000, 6'h00, wt);
    issue(OP_EXT, 0, 16'h0000, 16'h12F0, 16'hFFF0, 16'h0000, 6'h08, wt);
    issue(OP_BSW, 0, 16'h0000, 16'h12F0, 16'hF012, 16'h0000, 6'h08, wt);
    issue(OP_ADD, 0, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 6'h01, wt);
    issue(OP_LSR, 1, 16'h0000, 16'h0002, 16'h8001, 16'h0000, 6'h08, wt);
    issue(OP_ASL, 0, 16'h0000, 16'h8001, 16'h0002, 16'h0000, 6'h01, wt);
    issue(OP_ASL, 1, 16'h0000, 16'h4000, 16'h8001, 16'h0000, 6'h08, wt);
    issue(OP_LSR, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 6'h05, wt);
    issue(OP_ADD, 1, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 6'h00, wt);
    issue(OP_DEP, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'h04, wt);
    issue(OP_DEP, 0, 16'h0000, 16'h0003, 16'h0002, 16'h0000, 6'h10, wt);
    issue(OP_LDZ2, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 6'h04, wt);
    issue(OP_LDZ3, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 6'h04, wt);
    issue(OP_MUL, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 6'h01, wt);
    issue(OP_DIV, 0, 16'd100, 16'd7, 16'd14, 16'd2, 6'h00, wt);
    issue(OP_DIV, 0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 6'h00, wt);
    issue(OP_MUL, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 6'h04, wt);
    measure(lat, bcnt);

    issue(OP_MUL, 0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 6'h01, wt);
    measure(lat, bcnt);
    chk("mul_latency", lat, 17);
    chk("mul_busy_cycles", bcnt, 16);

    issue(OP_DIV, 0, 16'h00AA, 16'h0000, 16'hFFFF, 16'h00AA, 6'h2A, wt);
    measure(lat, bcnt);
    chk("div0_latency", lat, 17);

    out_ready = 0;
    issue(OP_ADD, 0, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 6'h00, wt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_d", d, 16'h0003);
      chk("bp_sf", sf, 16'h0000);
    end
    @(posedge clk);
    #1 out_ready = 1;
    issue(OP_EOR, 0, 16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 6'h00, wt);
    chk("bp_same_cycle", wt, 0);

    issue(OP_SUB, 0, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 6'h03, wt);
    issue(OP_MUL, 0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 6'h01, wt);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_sf", sf, 16'h0003);
    rst = 1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_sf", sf, 0);
    chk("rst_mid_busy", busy, 0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    repeat (25) @(negedge clk);
    chk("rst_abandon", out_valid, 0);
    @(posedge clk);
    #1;

    op_w(OP_SUB, 0, 32'd5, 32'd1, 32'd4, 6'h01);
    op_w(OP_ASL, 1, 32'd0, 32'h8000_0000, 32'h0000_0001, 6'h01);
    op_w(OP_LSR, 1, 32'd0, 32'h0000_0002, 32'h8000_0001, 6'h08);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
